// File: rtl/pipeline_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_control_unit_pkg
// Shared definitions for the pipeline latch stages and their control unit:
//   - ctrl_t  : 2-bit latch control code (TRANSFER / STALL / BUBBLE / CLEAR)
//   - state_t : hazard/control state machine encoding
//   - load_use_hazard() : load-use dependency detector
// -----------------------------------------------------------------------------
package pipeline_control_unit_pkg;

    // Latch control code understood by every pipeline latch stage.
    typedef enum logic [1:0] {
        CTRL_TRANSFER = 2'b00,  // latch captures its input
        CTRL_STALL    = 2'b01,  // latch holds its current content
        CTRL_BUBBLE   = 2'b10,  // latch loads a NOP
        CTRL_CLEAR    = 2'b11   // latch is cleared (reset only)
    } ctrl_t;

    // Control state machine encoding.
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_HOLD  = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_HALTED   = 2'b11
    } state_t;

    localparam int REG_W = 5;

    // A load in EX whose destination feeds the ID instruction; r0 never
    // creates a dependency because it is hardwired to zero.
    function automatic logic load_use_hazard(
        input logic             mem_read,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt
    );
        return mem_read && (rd != 5'd0) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for pipeline statistics.
// Ports:
//   clk   : clock, counts on posedge
//   rst   : synchronous active-high reset, clears count
//   inc   : increment request for this cycle
//   count : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_r;

    // Count register: clears on reset, increments until it reaches all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// pipeline_control_unit
// Central hazard controller for a 5-stage pipeline. It drives the control code
// of each pipeline latch plus the PC write enable, and keeps statistics.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_rs, id_rt             : source registers of the ID instruction
//   ex_rd, ex_mem_read       : destination / load flag of the EX instruction
//   ex_branch_taken          : branch resolved taken in EX
//   mem_busy                 : data memory cannot complete this cycle
//   wb_halt                  : halt instruction in WB
//   pc_we                    : PC write enable (combinational)
//   if_id_ctrl .. mem_wb_ctrl: latch control codes (combinational)
//   stall_cnt, flush_cnt, lu_cnt : saturating statistics counters
//   halted                   : pipeline frozen after a halt
// -----------------------------------------------------------------------------
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             wb_halt,
    output logic             pc_we,
    output logic [1:0]       if_id_ctrl,
    output logic [1:0]       id_ex_ctrl,
    output logic [1:0]       ex_mem_ctrl,
    output logic [1:0]       mem_wb_ctrl,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic             halted
);

    state_t state_r;
    state_t state_nxt_s;

    ctrl_t  if_id_s;
    ctrl_t  id_ex_s;
    ctrl_t  ex_mem_s;
    ctrl_t  mem_wb_s;
    logic   pc_we_s;
    logic   flush_ev_s;
    logic   lu_ev_s;
    logic   stall_ev_s;
    logic   lu_hazard_s;

    assign lu_hazard_s = load_use_hazard(ex_mem_read, ex_rd, id_rs, id_rt);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and latch controls, resolved in priority order. A branch or
    // load-use seen during mem_busy is not stored: the busy stall freezes the
    // pipeline, so the same inputs are presented again once memory is ready.
    always_comb begin
        state_nxt_s = ST_RUN;
        if_id_s     = CTRL_TRANSFER;
        id_ex_s     = CTRL_TRANSFER;
        ex_mem_s    = CTRL_TRANSFER;
        mem_wb_s    = CTRL_TRANSFER;
        pc_we_s     = 1'b1;
        flush_ev_s  = 1'b0;
        lu_ev_s     = 1'b0;
        if (rst) begin
            if_id_s     = CTRL_CLEAR;
            id_ex_s     = CTRL_CLEAR;
            ex_mem_s    = CTRL_CLEAR;
            mem_wb_s    = CTRL_CLEAR;
            pc_we_s     = 1'b0;
            state_nxt_s = ST_RUN;
        end else if ((state_r == ST_HALTED) || wb_halt) begin
            if_id_s     = CTRL_STALL;
            id_ex_s     = CTRL_STALL;
            ex_mem_s    = CTRL_STALL;
            mem_wb_s    = CTRL_STALL;
            pc_we_s     = 1'b0;
            state_nxt_s = ST_HALTED;
        end else if (mem_busy) begin
            if_id_s     = CTRL_STALL;
            id_ex_s     = CTRL_STALL;
            ex_mem_s    = CTRL_STALL;
            mem_wb_s    = CTRL_STALL;
            pc_we_s     = 1'b0;
            state_nxt_s = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
            // Squashing IF/ID and ID/EX also discards any load-use in ID.
            if_id_s     = CTRL_BUBBLE;
            id_ex_s     = CTRL_BUBBLE;
            flush_ev_s  = 1'b1;
            state_nxt_s = ST_RUN;
        end else if (lu_hazard_s && (state_r != ST_LU_HOLD)) begin
            // Masked in LU_HOLD: the load has already moved past EX.
            if_id_s     = CTRL_STALL;
            id_ex_s     = CTRL_BUBBLE;
            pc_we_s     = 1'b0;
            lu_ev_s     = 1'b1;
            state_nxt_s = ST_LU_HOLD;
        end else begin
            state_nxt_s = ST_RUN;
        end
    end

    assign if_id_ctrl  = if_id_s;
    assign id_ex_ctrl  = id_ex_s;
    assign ex_mem_ctrl = ex_mem_s;
    assign mem_wb_ctrl = mem_wb_s;
    assign pc_we       = pc_we_s;
    assign halted      = (state_r == ST_HALTED) && !rst;

    // The halt-entry cycle counts as a stall; frozen cycles afterwards do not.
    assign stall_ev_s  = !pc_we_s && (state_r != ST_HALTED) && !rst;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_ev_s),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_ev_s),
        .count (flush_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (lu_ev_s),
        .count (lu_cnt)
    );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// tb_pipeline_control_unit
// Directed bench: every step drives one cycle of inputs on the falling edge,
// pushes the expected control vector {if_id,id_ex,ex_mem,mem_wb,pc_we,halted}
// to a scoreboard queue, and pops/compares it shortly afterwards. Counters
// are checked against hand-computed totals.
// -----------------------------------------------------------------------------
module tb_pipeline_control_unit;

    localparam int CNT_W = 4;

    localparam logic [1:0] T = 2'b00;
    localparam logic [1:0] S = 2'b01;
    localparam logic [1:0] B = 2'b10;
    localparam logic [1:0] C = 2'b11;

    localparam logic [9:0] RUN_OK    = {T, T, T, T, 1'b1, 1'b0};
    localparam logic [9:0] STALL_ALL = {S, S, S, S, 1'b0, 1'b0};
    localparam logic [9:0] HALT_ALL  = {S, S, S, S, 1'b0, 1'b1};
    localparam logic [9:0] BRANCH    = {B, B, T, T, 1'b1, 1'b0};
    localparam logic [9:0] LOADUSE   = {S, B, T, T, 1'b0, 1'b0};
    localparam logic [9:0] IN_RESET  = {C, C, C, C, 1'b0, 1'b0};

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_busy;
    logic             wb_halt;
    logic             pc_we;
    logic [1:0]       if_id_ctrl;
    logic [1:0]       id_ex_ctrl;
    logic [1:0]       ex_mem_ctrl;
    logic [1:0]       mem_wb_ctrl;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] lu_cnt;
    logic             halted;

    typedef struct {
        string      tag;
        logic [9:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_assert;
    int   n_fail;

    pipeline_control_unit #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .wb_halt         (wb_halt),
        .pc_we           (pc_we),
        .if_id_ctrl      (if_id_ctrl),
        .id_ex_ctrl      (id_ex_ctrl),
        .ex_mem_ctrl     (ex_mem_ctrl),
        .mem_wb_ctrl     (mem_wb_ctrl),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .lu_cnt          (lu_cnt),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus check of the combinational outputs.
    task automatic step(input string tag, input logic r, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic mr, input logic bt, input logic mb,
                        input logic wh, input logic [9:0] exp_val);
        exp_t e;
        logic [9:0] obs;
        @(negedge clk);
        rst             = r;
        id_rs           = rs;
        id_rt           = rt;
        ex_rd           = rd;
        ex_mem_read     = mr;
        ex_branch_taken = bt;
        mem_busy        = mb;
        wb_halt         = wh;
        e.tag = tag;
        e.val = exp_val;
        sb.push_back(e);
        #2;
        obs = {if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl, pc_we, halted};
        e = sb.pop_front();
        n_assert++;
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
        end
    endtask

    task automatic idle(input string tag, input logic [9:0] exp_val);
        step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_val);
    endtask

    // Counters reflect all cycles up to, not including, the current step.
    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] es,
                             input logic [CNT_W-1:0] ef, input logic [CNT_W-1:0] el);
        n_assert++;
        assert ({stall_cnt, flush_cnt, lu_cnt} === {es, ef, el}) else begin
            n_fail++;
            $error("FAIL %s observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
                   stall_cnt, flush_cnt, lu_cnt, es, ef, el);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        ex_rd           = 5'd0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        mem_busy        = 1'b0;
        wb_halt         = 1'b0;

        // Reset: CLEAR everywhere, then counters zero.
        step("rst0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, IN_RESET);
        step("rst1", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IN_RESET);
        idle("run_after_rst", RUN_OK);
        check_cnt("cnt_reset", 4'd0, 4'd0, 4'd0);

        // Load-use on rs, then LU_HOLD masks the same hazard.
        step("lu", 1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LOADUSE);
        step("lu_hold", 1'b0, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, RUN_OK);
        idle("idle_lu", RUN_OK);
        check_cnt("cnt_lu", 4'd1, 4'd0, 4'd1);

        // r0 destination never causes a hazard.
        step("r0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, RUN_OK);
        idle("idle_r0", RUN_OK);
        check_cnt("cnt_r0", 4'd1, 4'd0, 4'd1);

        // Branch together with load-use: branch wins.
        step("br_lu", 1'b0, 5'd2, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, BRANCH);
        idle("idle_br", RUN_OK);
        check_cnt("cnt_br_lu", 4'd1, 4'd1, 4'd1);

        // Branch deferred across three busy cycles.
        for (int i = 0; i < 3; i++)
            step("busy_br", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, STALL_ALL);
        step("br_after_busy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BRANCH);
        idle("idle_busy", RUN_OK);
        check_cnt("cnt_busy_br", 4'd4, 4'd2, 4'd1);

        // Load-use deferred across a busy cycle.
        step("busy_lu", 1'b0, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, STALL_ALL);
        step("lu_after_busy", 1'b0, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LOADUSE);
        idle("idle_lu2", RUN_OK);
        check_cnt("cnt_busy_lu", 4'd6, 4'd2, 4'd2);

        // Branch arriving during LU_HOLD.
        step("lu3", 1'b0, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, LOADUSE);
        step("br_in_hold", 1'b0, 5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, BRANCH);
        idle("idle_hold", RUN_OK);
        check_cnt("cnt_hold_br", 4'd7, 4'd3, 4'd3);

        // Halt: entry cycle stalls and counts, then frozen regardless of inputs.
        step("halt_entry", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, STALL_ALL);
        step("halted_busy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, HALT_ALL);
        step("halted_br", 1'b0, 5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, HALT_ALL);
        step("halted_lu", 1'b0, 5'd6, 5'd6, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, HALT_ALL);
        idle("halted_idle", HALT_ALL);
        check_cnt("cnt_halted", 4'd8, 4'd3, 4'd3);

        // Reset out of HALTED.
        step("rst_halt0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, IN_RESET);
        step("rst_halt1", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, IN_RESET);
        idle("run_after_halt", RUN_OK);
        check_cnt("cnt_after_halt", 4'd0, 4'd0, 4'd0);

        // Saturation with 4-bit counters.
        for (int i = 0; i < 20; i++)
            step("sat_busy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STALL_ALL);
        idle("idle_sat", RUN_OK);
        check_cnt("cnt_sat", 4'd15, 4'd0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
